maxmin_sched: RTL

- Round-robin scheduler that shares one 8-bit max/min datapath among N_REQ requesters.
- Grants one requester at a time and forwards its 15-sample burst into the datapath through a registered stage.
- Waits for the datapath result, then returns max/min tagged with the requester id.
- Detects broken bursts and a silent datapath, and reports both on an error pulse.

---
 rtl/maxmin_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/maxmin_sched.sv
// Round-robin scheduler sharing one 8-bit max/min datapath among N_REQ requesters.
// Forwards a granted requester's fixed-length burst and returns the tagged result.
module maxmin_sched #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int BURST_LEN = 15,
  parameter int WAIT_MAX  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     lane_valid,
  input  logic [N_REQ*8-1:0]   lane_num,
  output logic [N_REQ-1:0]     grant,
  output logic                 mm_in_valid,
  output logic [7:0]           mm_in_num,
  input  logic                 mm_out_valid,
  input  logic [7:0]           mm_out_max,
  input  logic [7:0]           mm_out_min,
  output logic                 res_valid,
  output logic [7:0]           res_max,
  output logic [7:0]           res_min,
  output logic [ID_W-1:0]      res_id,
  output logic                 err,
  output logic [ID_W-1:0]      err_id
);

  localparam int CNT_MAX = (BURST_LEN > WAIT_MAX) ? BURST_LEN : WAIT_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, RESP} state_t;

  state_t            state_reg, state_next;
  logic [N_REQ-1:0]  grant_reg, grant_next;
  logic [ID_W-1:0]   gid_reg, gid_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              mm_in_valid_reg, mm_in_valid_next;
  logic [7:0]        mm_in_num_reg, mm_in_num_next;
  logic              res_valid_reg, res_valid_next;
  logic [7:0]        res_max_reg, res_max_next;
  logic [7:0]        res_min_reg, res_min_next;
  logic [ID_W-1:0]   res_id_reg, res_id_next;
  logic              err_reg, err_next;
  logic [ID_W-1:0]   err_id_reg, err_id_next;

  logic [ID_W-1:0]   cand_id [N_REQ];
  logic [7:0]        lane_arr [N_REQ];
  logic [ID_W-1:0]   win;
  logic              any_req;
  logic              sel_valid;
  logic [7:0]        sel_num;
  logic              burst_last;
  logic              wait_expired;

  // cand_id[k] is the requester examined k-th when searching upward from the pointer
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign cand_id[gi]  = ID_W'((int'(ptr_reg) + gi) % N_REQ);
    assign lane_arr[gi] = lane_num[8*gi +: 8];
  end

  always_comb begin
    any_req = |req;
    win     = ptr_reg;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[cand_id[k]]) win = cand_id[k];
    end
  end

  assign sel_valid    = lane_valid[gid_reg];
  assign sel_num      = lane_arr[gid_reg];
  assign burst_last   = (cnt_reg == CNT_W'(BURST_LEN - 1));
  assign wait_expired = (cnt_reg == CNT_W'(WAIT_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (any_req) state_next = STREAM;
      STREAM: if (!sel_valid) state_next = IDLE;
              else if (burst_last) state_next = WAIT;
      WAIT:   if (mm_out_valid) state_next = RESP;
              else if (wait_expired) state_next = IDLE;
      RESP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_next       = '0;
    gid_next         = gid_reg;
    ptr_next         = ptr_reg;
    cnt_next         = '0;
    mm_in_valid_next = 1'b0;
    mm_in_num_next   = mm_in_num_reg;
    res_valid_next   = 1'b0;
    res_max_next     = res_max_reg;
    res_min_next     = res_min_reg;
    res_id_next      = res_id_reg;
    err_next         = 1'b0;
    err_id_next      = err_id_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          grant_next = N_REQ'(1) << win;
          gid_next   = win;
          ptr_next   = ID_W'((int'(win) + 1) % N_REQ);
        end
      end
      STREAM: begin
        mm_in_valid_next = sel_valid;
        mm_in_num_next   = sel_num;
        if (!sel_valid) begin
          err_next    = 1'b1;
          err_id_next = gid_reg;
        end else if (!burst_last) begin
          grant_next = grant_reg;
          cnt_next   = cnt_reg + 1'b1;
        end
      end
      WAIT: begin
        // Counter restarts at 0 on entry, so it counts cycles since the last forwarded sample
        cnt_next = cnt_reg + 1'b1;
        if (mm_out_valid) begin
          res_valid_next = 1'b1;
          res_max_next   = mm_out_max;
          res_min_next   = mm_out_min;
          res_id_next    = gid_reg;
        end else if (wait_expired) begin
          err_next    = 1'b1;
          err_id_next = gid_reg;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_reg       <= '0;
      gid_reg         <= '0;
      ptr_reg         <= '0;
      cnt_reg         <= '0;
      mm_in_valid_reg <= 1'b0;
      mm_in_num_reg   <= 8'd0;
      res_valid_reg   <= 1'b0;
      res_max_reg     <= 8'd0;
      res_min_reg     <= 8'd255;
      res_id_reg      <= '0;
      err_reg         <= 1'b0;
      err_id_reg      <= '0;
    end else begin
      grant_reg       <= grant_next;
      gid_reg         <= gid_next;
      ptr_reg         <= ptr_next;
      cnt_reg         <= cnt_next;
      mm_in_valid_reg <= mm_in_valid_next;
      mm_in_num_reg   <= mm_in_num_next;
      res_valid_reg   <= res_valid_next;
      res_max_reg     <= res_max_next;
      res_min_reg     <= res_min_next;
      res_id_reg      <= res_id_next;
      err_reg         <= err_next;
      err_id_reg      <= err_id_next;
    end
  end

  assign grant       = grant_reg;
  assign mm_in_valid = mm_in_valid_reg;
  assign mm_in_num   = mm_in_num_reg;
  assign res_valid   = res_valid_reg;
  assign res_max     = res_max_reg;
  assign res_min     = res_min_reg;
  assign res_id      = res_id_reg;
  assign err         = err_reg;
  assign err_id      = err_id_reg;

endmodule
